// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over an abortable
// req/ack handshake, and buffers {PC+4, instruction} pairs in a small FIFO
// that feeds the IF/ID pipeline register.
module if_prefetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Address,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ack,
    input  logic [31:0] IM_Data,
    output logic [31:0] PC_Out,
    output logic [31:0] Instruction_Out,
    output logic        Valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_pc4_q   [DEPTH];
    logic [31:0]   fifo_pc4_d   [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    logic          valid_s;
    logic          req_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   pc_plus4_s;

    // Handshake and FIFO control decoded from registered state plus the redirect pulse.
    always_comb begin
        valid_s    = (count_q != {CW{1'b0}});
        req_s      = RST && !Branch_Taken && (count_q < FULL_CNT);
        push_s     = req_s && IM_Ack;
        pop_s      = valid_s && !freeze && !Branch_Taken;
        pc_plus4_s = pc_q + 32'd4;
    end

    // Next-state for PC, pointers, count and FIFO storage; redirect overrides everything.
    always_comb begin
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_pc4_d   = fifo_pc4_q;
        fifo_instr_d = fifo_instr_q;
        if (Branch_Taken) begin
            pc_d     = Branch_Address;
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc4_d[wr_ptr_q]   = pc_plus4_s;
                fifo_instr_d[wr_ptr_q] = IM_Data;
                wr_ptr_d               = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                pc_d                   = pc_plus4_s;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // State register with synchronous active-low reset; reset flushes the FIFO.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc4_q[i]   <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_pc4_q   <= fifo_pc4_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

    // Output drive: an empty FIFO presents an all-zero null instruction.
    always_comb begin
        IM_Req  = req_s;
        IM_Addr = pc_q;
        Valid   = valid_s;
        if (valid_s) begin
            PC_Out          = fifo_pc4_q[rd_ptr_q];
            Instruction_Out = fifo_instr_q[rd_ptr_q];
        end else begin
            PC_Out          = 32'h0000_0000;
            Instruction_Out = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed vector table, a wait-state sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_if_prefetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        freeze;
    logic        Branch_Taken;
    logic [31:0] Branch_Address;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Ack;
    logic [31:0] IM_Data;
    logic [31:0] PC_Out;
    logic [31:0] Instruction_Out;
    logic        Valid;

    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST(RST), .freeze(freeze),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .IM_Req(IM_Req), .IM_Addr(IM_Addr), .IM_Ack(IM_Ack), .IM_Data(IM_Data),
        .PC_Out(PC_Out), .Instruction_Out(Instruction_Out), .Valid(Valid)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        bt;
        logic [31:0] ba;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[19];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the FIFO and PC become at a clock edge.
    task automatic model_edge(input logic rst, input logic frz, input logic bt,
                              input logic [31:0] ba, input logic ack, input logic [31:0] data);
        bit req;
        bit vld;
        entry_t e;
        req = rst && !bt && (mq.size() < DEPTH);
        vld = (mq.size() != 0);
        if (!rst) begin
            mq.delete();
            m_pc = RESET_PC;
        end else if (bt) begin
            mq.delete();
            m_pc = ba;
        end else begin
            if (vld && !frz) void'(mq.pop_front());
            if (req && ack) begin
                e.pc4   = m_pc + 32'd4;
                e.instr = data;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle: drive just after the edge, check mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic frz, input logic bt, input logic [31:0] ba,
                        input logic ack, input bit use_tbl, input vec_t v);
        logic [31:0] data;
        RST = rst; freeze = frz; Branch_Taken = bt; Branch_Address = ba; IM_Ack = ack;
        data = rom(m_pc);
        IM_Data = data;
        #1;
        if (use_tbl) begin
            chk("tbl_req",   {31'd0, IM_Req}, {31'd0, v.exp_req});
            chk("tbl_addr",  IM_Addr, v.exp_addr);
            chk("tbl_valid", {31'd0, Valid}, {31'd0, v.exp_valid});
            chk("tbl_pcout", PC_Out, v.exp_pc);
            chk("tbl_instr", Instruction_Out, v.exp_instr);
        end else begin
            chk("mdl_req",   {31'd0, IM_Req},
                {31'd0, (rst && !bt && (mq.size() < DEPTH)) ? 1'b1 : 1'b0});
            chk("mdl_addr",  IM_Addr, m_pc);
            chk("mdl_valid", {31'd0, Valid}, {31'd0, (mq.size() != 0) ? 1'b1 : 1'b0});
            chk("mdl_pcout", PC_Out, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
            chk("mdl_instr", Instruction_Out, (mq.size() != 0) ? mq[0].instr : 32'h0);
        end
        @(posedge CLK);
        model_edge(rst, frz, bt, ba, ack, data);
        #1;
    endtask

    initial begin
        vec_t        nv;
        logic [31:0] held_addr;
        nv = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};

        //        rst  frz  bt   ba            ack  req  addr          vld  pc_out        instr
        tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h0000_0004,1'b1,32'h0000_0004,32'hA5A5_0000};
        tbl[3]  = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b1,32'h0000_0008,1'b1,32'h0000_0008,32'hA5A5_0004};
        tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0000_000C,1'b1,32'h0000_0008,32'hA5A5_0004};
        tbl[5]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0000_000C,1'b1,32'h0000_0008,32'hA5A5_0004};
        tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h0000_000C,1'b1,32'h0000_000C,32'hA5A5_0008};
        tbl[7]  = '{1'b1,1'b1,1'b1,32'h100,     1'b1,1'b0,32'h0000_0010,1'b1,32'h0000_0010,32'hA5A5_000C};
        tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h0000_0100,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0000_0104,1'b1,32'h0000_0104,32'hA5A5_0100};
        tbl[10] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0000_0104,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[11] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b0,32'h0000_0104,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[12] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hFFFF_FFFC,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[13] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0000_0000,1'b1,32'h0000_0000,32'h5A5A_FFFC};
        tbl[14] = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b1,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[15] = '{1'b1,1'b1,1'b0,32'h0,       1'b1,1'b1,32'h0000_0004,1'b1,32'h0000_0004,32'hA5A5_0000};
        tbl[16] = '{1'b0,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0000_0008,1'b1,32'h0000_0004,32'hA5A5_0000};
        tbl[17] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000};
        tbl[18] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h0000_0004,1'b1,32'h0000_0004,32'hA5A5_0000};

        RST = 1'b0; freeze = 1'b0; Branch_Taken = 1'b0; Branch_Address = 32'h0;
        IM_Ack = 1'b0; IM_Data = 32'h0;
        m_pc = RESET_PC;
        @(posedge CLK);
        #1;

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].frz, tbl[i].bt, tbl[i].ba, tbl[i].ack, 1'b1, tbl[i]);
        end

        // Wait-state memory: ack on the 4th cycle of each request, address must hold.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, nv);
        for (int k = 0; k < 12; k++) begin
            held_addr = IM_Addr;
            step(1'b1, 1'b0, 1'b0, 32'h0, (k % 4 == 3) ? 1'b1 : 1'b0, 1'b0, nv);
            if (k % 4 != 3) chk("ws_addr_stable", IM_Addr, held_addr);
            else            chk("ws_valid_pulse", {31'd0, Valid}, 32'd1);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 $urandom(),
                 $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
                 1'b0, nv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
